// File: rtl/lru_repl_ctrl.sv
// lru_repl_ctrl: per-set LRU rank store with touch/invalidate updates and a registered victim port.
module lru_repl_ctrl #(
    parameter int WAYS  = 8,
    parameter int SETS  = 128,
    parameter int WAY_W = $clog2(WAYS),
    parameter int SET_W = $clog2(SETS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   touch_valid,
    input  logic [SET_W-1:0]       touch_set,
    input  logic [WAY_W-1:0]       touch_way,
    input  logic                   inval_valid,
    output logic                   inval_ready,
    input  logic [SET_W-1:0]       inval_set,
    input  logic [WAY_W-1:0]       inval_way,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SET_W-1:0]       req_set,
    output logic                   vic_valid,
    input  logic                   vic_ready,
    output logic [WAY_W-1:0]       vic_way,
    output logic [WAY_W+SET_W-1:0] vic_index
);
    typedef logic [WAYS-1:0][WAY_W-1:0] row_t;
    row_t                   rank_q [SETS];
    row_t                   upd_row, row_d, req_row;
    logic                   upd_en;
    logic [SET_W-1:0]       upd_set;
    logic [WAY_W-1:0]       upd_way, old_rank, min_way, min_rank;
    logic                   vic_valid_q;
    logic [WAY_W-1:0]       vic_way_q;
    logic [WAY_W+SET_W-1:0] vic_index_q;
    // A touch always wins the single update port; the invalidate is back-pressured.
    assign inval_ready = !touch_valid;
    assign req_ready   = !vic_valid_q || vic_ready;
    assign upd_en      = touch_valid || inval_valid;
    assign upd_set     = touch_valid ? touch_set : inval_set;
    assign upd_way     = touch_valid ? touch_way : inval_way;
    assign upd_row     = rank_q[upd_set];
    assign old_rank    = upd_row[upd_way];
    assign req_row     = rank_q[req_set];
    assign vic_valid   = vic_valid_q;
    assign vic_way     = vic_way_q;
    assign vic_index   = vic_index_q;
    always_comb begin
        row_d = upd_row;
        for (int w = 0; w < WAYS; w++)
            row_d[w] = touch_valid
                ? (WAY_W'(w) == upd_way ? WAY_W'(WAYS-1) : upd_row[w] > old_rank ? upd_row[w] - 1'b1 : upd_row[w])
                : (WAY_W'(w) == upd_way ? '0 : upd_row[w] < old_rank ? upd_row[w] + 1'b1 : upd_row[w]);
    end
    // Strict less-than keeps the lowest-numbered way on a tie.
    always_comb begin
        min_way  = '0;
        min_rank = req_row[0];
        for (int w = 1; w < WAYS; w++)
            if (req_row[w] < min_rank) begin
                min_rank = req_row[w];
                min_way  = WAY_W'(w);
            end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    rank_q[s][w] <= WAY_W'(w);
        end else if (upd_en) begin
            rank_q[upd_set] <= row_d;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vic_valid_q <= 1'b0;
            vic_way_q   <= '0;
            vic_index_q <= '0;
        end else if (req_valid && req_ready) begin
            vic_valid_q <= 1'b1;
            vic_way_q   <= min_way;
            vic_index_q <= {min_way, req_set};
        end else if (vic_ready) begin
            vic_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lru_repl_ctrl.sv
// tb_lru_repl_ctrl: scoreboard bench with directed vectors, a recency-list reference model and a random soak.
module tb_lru_repl_ctrl;
    localparam int WAYS = 8;
    localparam int SETS = 128;
    localparam int WAY_W = 3;
    localparam int SET_W = 7;
    logic clk = 0, rst = 1;
    logic touch_valid = 0, inval_valid = 0, req_valid = 0, vic_ready = 1;
    logic [SET_W-1:0] touch_set = 0, inval_set = 0, req_set = 0;
    logic [WAY_W-1:0] touch_way = 0, inval_way = 0;
    logic inval_ready, req_ready, vic_valid;
    logic [WAY_W-1:0] vic_way;
    logic [WAY_W+SET_W-1:0] vic_index;
    int n_vec = 0, n_err = 0;
    int q_way[$], q_idx[$];
    int ord [SETS][WAYS];
    lru_repl_ctrl #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst(rst),
        .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
        .inval_valid(inval_valid), .inval_ready(inval_ready), .inval_set(inval_set), .inval_way(inval_way),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
        .vic_valid(vic_valid), .vic_ready(vic_ready), .vic_way(vic_way), .vic_index(vic_index)
    );
    always #5 clk = ~clk;
    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && vic_valid && vic_ready) begin
            if (q_way.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                chk("vic_way", vic_way, q_way.pop_front());
                chk("vic_index", vic_index, q_idx.pop_front());
            end
        end
    end
    // Reference model: ord[s] lists ways from LRU (position 0) to MRU.
    task automatic m_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) ord[s][w] = w;
    endtask
    function automatic int m_pos(int s, int w);
        for (int p = 0; p < WAYS; p++) if (ord[s][p] == w) return p;
        return -1;
    endfunction
    task automatic m_touch(int s, int w);
        for (int p = m_pos(s, w); p < WAYS - 1; p++) ord[s][p] = ord[s][p+1];
        ord[s][WAYS-1] = w;
    endtask
    task automatic m_inval(int s, int w);
        for (int p = m_pos(s, w); p > 0; p--) ord[s][p] = ord[s][p-1];
        ord[s][0] = w;
    endtask
    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    // ew >= 0 is a hand-computed expected victim; ew < 0 takes it from the model.
    task automatic step(bit tv, int ts, int tw, bit iv, int is_, int iw, bit rv, int rs, int ew);
        int e;
        touch_valid = tv; touch_set = SET_W'(ts); touch_way = WAY_W'(tw);
        inval_valid = iv; inval_set = SET_W'(is_); inval_way = WAY_W'(iw);
        req_valid = rv; req_set = SET_W'(rs);
        #1;
        if (iv) chk("inval_ready", inval_ready, !tv);
        if (rv && req_ready) begin
            e = ew < 0 ? ord[rs][0] : ew;
            q_way.push_back(e);
            q_idx.push_back(e * SETS + rs);
        end
        if (tv) m_touch(ts, tw);
        else if (iv) m_inval(is_, iw);
        @(posedge clk); #1;
        touch_valid = 0; inval_valid = 0; req_valid = 0;
    endtask
    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_vic_valid", vic_valid, 0);
        q_way.delete(); q_idx.delete();
        m_reset();
        idle(2);
        rst = 0;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
    initial begin
        m_reset();
        idle(2);
        chk("reset_vic_valid", vic_valid, 0);
        chk("reset_vic_way", vic_way, 0);
        chk("reset_vic_index", vic_index, 0);
        rst = 0;
        idle(1);
        // 1-2: identity victims, then independence of sets
        step(0,0,0, 0,0,0, 1,5, 0);
        step(1,5,0, 0,0,0, 0,0, 0);
        step(0,0,0, 0,0,0, 1,5, 1);
        step(0,0,0, 0,0,0, 1,6, 0);
        // 3: fill most ways of set 3, invalidate, re-touch
        for (int w = 0; w < 7; w++) step(1,3,w, 0,0,0, 0,0, 0);
        step(0,0,0, 0,0,0, 1,3, 7);
        step(0,0,0, 1,3,4, 0,0, 0);
        step(0,0,0, 0,0,0, 1,3, 4);
        step(1,3,4, 0,0,0, 0,0, 0);
        step(0,0,0, 0,0,0, 1,3, 7);
        idle(2);
        // 4: stalled consumer holds the result and blocks new requests
        vic_ready = 0;
        step(0,0,0, 0,0,0, 1,5, 1);
        req_valid = 1; req_set = 6;
        for (int i = 0; i < 5; i++) begin
            chk("hold_req_ready", req_ready, 0);
            chk("hold_vic_valid", vic_valid, 1);
            chk("hold_vic_way", vic_way, 1);
            chk("hold_vic_index", vic_index, 133);
            idle(1);
        end
        vic_ready = 1;
        step(0,0,0, 0,0,0, 1,6, 0);
        idle(3);
        chk("drain_after_stall", q_way.size(), 0);
        // 5: same-cycle interactions
        do_reset();
        idle(1);
        step(1,2,0, 0,0,0, 1,2, 0);
        step(0,0,0, 0,0,0, 1,2, 1);
        step(1,2,3, 1,2,6, 0,0, 0);
        step(0,0,0, 0,0,0, 1,2, 1);
        step(0,0,0, 1,2,6, 0,0, 0);
        step(0,0,0, 0,0,0, 1,2, 6);
        step(0,0,0, 1,2,6, 1,2, 6);
        step(0,0,0, 0,0,0, 1,2, 6);
        // 6: reset with a pending result, touches ignored during reset
        vic_ready = 0;
        step(0,0,0, 0,0,0, 1,3, -1);
        chk("pending_vic_valid", vic_valid, 1);
        rst = 1;
        #1;
        chk("mid_rst_vic_valid", vic_valid, 0);
        q_way.delete(); q_idx.delete();
        m_reset();
        vic_ready = 1;
        touch_valid = 1; touch_set = 0; touch_way = 0;
        inval_valid = 1; inval_set = 1; inval_way = 7;
        idle(2);
        touch_valid = 0; inval_valid = 0;
        rst = 0;
        idle(1);
        step(0,0,0, 0,0,0, 1,2, 0);
        step(0,0,0, 0,0,0, 1,0, 0);
        step(0,0,0, 0,0,0, 1,1, 0);
        // random soak on a few sets so events collide
        for (int i = 0; i < 400; i++)
            step($urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,7),
                 $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,7),
                 $urandom_range(0,1), $urandom_range(0,3), -1);
        idle(3);
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < WAYS; w++)
                chk($sformatf("rank_s%0d_w%0d", s, w), int'(dut.rank_q[s][w]), m_pos(s, w));
        chk("final_drain", q_way.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lru_repl_ctrl.md
Name: lru_repl_ctrl

Overview:
- Parametrised, stateful LRU replacement controller for the set-associative compressed cache.
- Holds a per-set, per-way recency rank; updates ranks on hit/fill (touch) and invalidate; answers victim queries with the least-recently-used way and the flat line index.
- Successor to the combinational 8-way minimum selector. Adds stored state, generic ways/sets, invalidate support and a registered valid/ready victim port.

Parameters:
- WAYS, 8, associativity; power of two, 2..16.
- SETS, 128, number of sets; power of two.
- WAY_W, $clog2(WAYS), derived; way-number width and rank width.
- SET_W, $clog2(SETS), derived; set-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- touch_valid  in  1  hit/fill event this cycle; always accepted.
- touch_set  in  SET_W  set of the touch.
- touch_way  in  WAY_W  way made most-recently-used.
- inval_valid  in  1  invalidate event.
- inval_ready  out  1  = !touch_valid; invalidate is accepted only when high.
- inval_set  in  SET_W  set of the invalidate.
- inval_way  in  WAY_W  way made least-recently-used.
- req_valid  in  1  victim query.
- req_ready  out  1  = !vic_valid || vic_ready.
- req_set  in  SET_W  set being queried.
- vic_valid  out  1  victim result valid.
- vic_ready  in  1  consumer accepts the result.
- vic_way  out  WAY_W  LRU way.
- vic_index  out  WAY_W+SET_W  line index = vic_way*SETS + set (way in MSBs, set in LSBs).

Behaviour:
- State: rank[s][w], WAY_W bits each. The ranks of one set always form a permutation of 0..WAYS-1. 0 = LRU, WAYS-1 = MRU.
- Reset (async, during rst): rank[s][w] = w for every set; vic_valid = 0; vic_way = 0; vic_index = 0.
- Touch (touch_valid=1), with old = rank[S][W]:
  - rank[S][W] becomes WAYS-1.
  - Every other way in set S with rank > old is decremented.
  - Other sets are unchanged.
  - Touching the way that is already MRU leaves the set unchanged.
- Invalidate (inval_valid && inval_ready), with old = rank[S][W]:
  - rank[S][W] becomes 0.
  - Every other way in set S with rank < old is incremented.
  - Invalidating the way that is already LRU leaves the set unchanged.
- Touch and invalidate in the same cycle: the touch is performed and the invalidate is not accepted. This holds whether or not the sets match. The requester holds the invalidate until inval_ready is high.
- Victim query:
  - Accepted when req_valid && req_ready.
  - The way with rank 0 in req_set is found combinationally from the current (pre-edge) state.
  - vic_way and vic_index are registered; vic_valid rises on the next cycle (1-cycle latency).
  - Tie-break: not reachable while the permutation invariant holds. If it is ever broken, the lowest-numbered way with the minimum rank is chosen.
- Query in the same cycle as a touch or invalidate of the same set: the result reflects the state before the update.
- Output register:
  - While vic_valid && !vic_ready, vic_way, vic_index and vic_valid hold, and req_ready = 0.
  - When vic_valid && vic_ready && a new request is accepted in the same cycle, back-to-back results are produced with no bubble.
  - When vic_valid && vic_ready and no request is accepted, vic_valid falls.
- A query does not modify ranks. The cache issues a touch for the filled way after allocation.
- rst asserted mid-operation: all ranks return to identity and a pending vic_valid is dropped immediately. Touches and invalidates presented during rst are ignored.
- Out-of-range inputs: cannot occur, because all widths are exact powers of two.

Test Plan:
1. Reset, then query set 5 with vic_ready=1 -> next cycle vic_valid=1, vic_way=0, vic_index=5.
2. Touch set 5 way 0, then query set 5 -> vic_way=1, vic_index=133. Query set 6 -> vic_way=0, vic_index=6 (sets are independent).
3. Touch set 3 ways 0,1,2,3,4,5,6 in order, then query -> vic_way=7, vic_index=899. Then invalidate set 3 way 4 and query -> vic_way=4, vic_index=515. Then touch way 4 and query -> vic_way=7.
4. Hold vic_ready=0 with a result pending, present a second req -> req_ready=0, result held stable for 5 cycles. Raise vic_ready -> second request is accepted that cycle, and its result appears on the next cycle.
5. From reset: in one cycle, touch set 2 way 0 and query set 2 -> vic_way=0 (pre-update). A following query of set 2 -> vic_way=1. Touch plus invalidate in the same cycle -> inval_ready=0 and ranks reflect the touch only.
6. Assert rst while vic_valid=1 and mid-sequence -> vic_valid=0 immediately. After release, query any set -> vic_way=0. Random touch/invalidate soak: check per-set permutation and that every result matches a reference-model LRU.
